// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR memory controller.
package mem_pkg;

  // MDR source selection
  typedef enum logic [1:0] {
    SEL_BUS  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_HOLD = 2'b10,
    SEL_SPC  = 2'b11
  } sel_mdr_e;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  // First memory-mapped I/O address
  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFE00;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_W.
// Write on the rising edge when i_wren; the read is registered (one-cycle latency).
// Contents are not reset.
module mem_array #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 16
) (
  input  logic                  i_clk,
  input  logic                  i_wren,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_q
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_q;

  // Write port and registered read port
  always_ff @(posedge i_clk) begin
    if (i_wren) r_mem[i_addr] <= i_wdata;
    r_q <= r_mem[i_addr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_ctrl.sv
// MAR/MDR registers, handshaked RAM access FSM with WAIT_CYCLES latency and a
// one-cycle ready pulse (mem_r). Optional memory-mapped I/O window is enabled
// with the MEM_MMIO_EN macro; without it the whole address space maps to RAM.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        DEPTH_LOG2  = 16,
  parameter int unsigned        WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0]  MMIO_BASE   = ADDR_W'(MMIO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic              ldMAR,
  input  logic              ldMARSpcIn,
  input  logic [ADDR_W-1:0] MARSpcIn,
  input  logic              ldMDR,
  input  logic [1:0]        selMDR,
  input  logic [DATA_W-1:0] MDRSpcIn,
  input  logic              mem_en,
  input  logic              mem_we,
  output logic              mem_r,
  output logic              busy,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] MAROut,
  output logic [DATA_W-1:0] MDROut,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_req_we;
  logic [DATA_W-1:0] r_rdata_hold;
  logic [3:0]        r_cnt;
  mem_state_e        r_state;

  logic              w_done;
  logic              w_is_io;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_q;
  logic [DATA_W-1:0] w_rdata;

  assign w_done = (r_state == DONE);

`ifdef MEM_MMIO_EN
  assign w_is_io  = (r_req_addr >= MMIO_BASE);
  assign w_rdata  = w_is_io ? io_rdata : w_q;
  assign io_we    = w_done & r_req_we & w_is_io;
  assign io_addr  = r_req_addr;
  assign io_wdata = r_req_wdata;
`else
  logic w_unused;
  assign w_is_io  = 1'b0;
  assign w_rdata  = w_q;
  assign io_we    = 1'b0;
  assign io_addr  = '0;
  assign io_wdata = '0;
  assign w_unused = ^{io_rdata, MMIO_BASE, r_req_addr};
`endif

  assign w_ram_we  = w_done & r_req_we & ~w_is_io;
  assign mem_r     = w_done;
  assign busy      = (r_state == BUSY);
  assign mem_rdata = w_done ? w_rdata : r_rdata_hold;
  assign MAROut    = r_mar;
  assign MDROut    = r_mdr;

  // MAR/MDR loads; special MAR source wins over the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (ldMARSpcIn)  r_mar <= MARSpcIn;
      else if (ldMAR)  r_mar <= ADDR_W'(Bus);
      if (ldMDR) begin
        case (sel_mdr_e'(selMDR))
          SEL_BUS: r_mdr <= Bus;
          SEL_MEM: r_mdr <= mem_rdata;
          SEL_SPC: r_mdr <= MDRSpcIn;
          default: r_mdr <= r_mdr;
        endcase
      end
    end
  end

  // Access FSM: address/data/direction are latched at acceptance so MAR/MDR
  // may change while the access is in flight. DONE may accept directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (mem_en) begin
            r_req_addr  <= r_mar;
            r_req_wdata <= r_mdr;
            r_req_we    <= mem_we;
            r_cnt       <= LP_WAIT;
            r_state     <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Hold read data outside the ready cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_rdata_hold <= '0;
    else if (w_done) r_rdata_hold <= w_rdata;
  end

  // The array address is req_addr throughout BUSY, so the registered read
  // taken at the last BUSY edge presents q in the DONE cycle.
  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .i_clk   (clk),
    .i_wren  (w_ram_we),
    .i_addr  (r_req_addr[DEPTH_LOG2-1:0]),
    .i_wdata (r_req_wdata),
    .o_q     (w_q)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl (WAIT_CYCLES=3, DEPTH_LOG2=8).
module tb_mem_ctrl;

  localparam int unsigned WAITC = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] Bus = '0;
  logic        ldMAR = 1'b0;
  logic        ldMARSpcIn = 1'b0;
  logic [15:0] MARSpcIn = '0;
  logic        ldMDR = 1'b0;
  logic [1:0]  selMDR = 2'b00;
  logic [15:0] MDRSpcIn = '0;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic        mem_r;
  logic        busy;
  logic [15:0] mem_rdata;
  logic [15:0] MAROut;
  logic [15:0] MDROut;
  logic        io_we;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_ctrl #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .DEPTH_LOG2  (8),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Bus        (Bus),
    .ldMAR      (ldMAR),
    .ldMARSpcIn (ldMARSpcIn),
    .MARSpcIn   (MARSpcIn),
    .ldMDR      (ldMDR),
    .selMDR     (selMDR),
    .MDRSpcIn   (MDRSpcIn),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_r      (mem_r),
    .busy       (busy),
    .mem_rdata  (mem_rdata),
    .MAROut     (MAROut),
    .MDROut     (MDROut),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input logic [15:0] a);
    Bus = a; ldMAR = 1'b1;
    step();
    ldMAR = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] d);
    Bus = d; ldMDR = 1'b1; selMDR = 2'b00;
    step();
    ldMDR = 1'b0;
  endtask

  // One access from IDLE; checks latency and busy, returns the DONE-cycle read data.
  task automatic access(input string tag, input logic we, input logic ld_mem,
                        output logic [15:0] rdata);
    int n;
    mem_en = 1'b1; mem_we = we;
    step();
    mem_en = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!mem_r && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(WAITC));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    rdata = mem_rdata;
    if (ld_mem) begin ldMDR = 1'b1; selMDR = 2'b01; end
    step();
    ldMDR = 1'b0; selMDR = 2'b00;
  endtask

  task automatic write_word(input string tag, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] rd;
    set_mar(a);
    set_mdr(d);
    access(tag, 1'b1, 1'b0, rd);
  endtask

  task automatic read_word(input string tag, input logic [15:0] a, output logic [15:0] rd);
    set_mar(a);
    access(tag, 1'b0, 1'b0, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int cnt;

    // Reset state
    #2;
    check("rst_mar", 32'(MAROut), 32'h0);
    check("rst_mdr", 32'(MDROut), 32'h0);
    check("rst_mem_r", 32'(mem_r), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_io_we", 32'(io_we), 32'h0);
    #5 reset = 1'b1;
    step();

    // Reset mid-write must abort the commit
    write_word("pre3000", 16'h3000, 16'h1111);
    set_mar(16'h3000);
    set_mdr(16'hBEEF);
    mem_en = 1'b1; mem_we = 1'b1;
    step();
    mem_en = 1'b0;
    step();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_r", 32'(mem_r), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mar", 32'(MAROut), 32'h0);
    #3 reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_r) cnt++;
    end
    check("abort_no_r", 32'(cnt), 32'd0);
    read_word("rd3000", 16'h3000, rd);
    check("rd3000_data", 32'(rd), 32'h1111);

    // Write then read, MDR loaded from memory data
    write_word("wr0040", 16'h0040, 16'h1234);
    set_mdr(16'h0000);
    set_mar(16'h0040);
    access("rd0040", 1'b0, 1'b1, rd);
    check("rd0040_mdr", 32'(MDROut), 32'h1234);
    check("rd0040_hold", 32'(mem_rdata), 32'h1234);

    // Back-to-back reads with MAR changed while busy
    write_word("wr0010", 16'h0010, 16'hA010);
    write_word("wr0011", 16'h0011, 16'hA011);
    set_mar(16'h0010);
    mem_en = 1'b1; mem_we = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_r%0d", i), 32'(mem_r), 32'((i == 3) || (i == 7)));
      check($sformatf("b2b_busy%0d", i), 32'(busy), 32'(!((i == 3) || (i == 7))));
      if (i == 3) check("b2b_d0", 32'(mem_rdata), 32'hA010);
      if (i == 7) check("b2b_d1", 32'(mem_rdata), 32'hA011);
      if (i == 0) begin Bus = 16'h0011; ldMAR = 1'b1; end
      if (i == 1) ldMAR = 1'b0;
      if (i == 7) mem_en = 1'b0;
      step();
    end
    check("b2b_idle", 32'(busy), 32'd0);

    // MAR source priority
    Bus = 16'h0AAA; ldMAR = 1'b1; MARSpcIn = 16'h0BBB; ldMARSpcIn = 1'b1;
    step();
    ldMAR = 1'b0; ldMARSpcIn = 1'b0;
    check("mar_prio", 32'(MAROut), 32'h0BBB);

    // MDR hold and special source
    set_mdr(16'h5A5A);
    ldMDR = 1'b1; selMDR = 2'b10; Bus = 16'hFFFF;
    step();
    check("mdr_hold", 32'(MDROut), 32'h5A5A);
    selMDR = 2'b11; MDRSpcIn = 16'hC3C3;
    step();
    ldMDR = 1'b0; selMDR = 2'b00;
    check("mdr_spc", 32'(MDROut), 32'hC3C3);

    // mem_en during BUSY is ignored
    mem_en = 1'b1; mem_we = 1'b0;
    step();
    mem_en = 1'b0;
    step();
    mem_en = 1'b1;
    step();
    mem_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_r) cnt++;
      step();
    end
    check("ignore_one_r", 32'(cnt), 32'd1);

    // Address aliasing above DEPTH_LOG2
    write_word("wr0105", 16'h0105, 16'hAAAA);
    read_word("rd0005", 16'h0005, rd);
    check("alias_data", 32'(rd), 32'hAAAA);

    write_word("wr0006", 16'h0006, 16'h5555);
`ifdef MEM_MMIO_EN
    // MMIO write strobes io_we in DONE and leaves RAM untouched
    set_mar(16'hFE06);
    set_mdr(16'h0041);
    mem_en = 1'b1; mem_we = 1'b1;
    step();
    mem_en = 1'b0;
    cnt = 0;
    while (!mem_r && cnt < 20) begin
      check("io_we_quiet", 32'(io_we), 32'd0);
      step();
      cnt++;
    end
    check("io_lat", 32'(cnt), 32'(WAITC));
    check("io_we", 32'(io_we), 32'd1);
    check("io_addr", 32'(io_addr), 32'hFE06);
    check("io_wdata", 32'(io_wdata), 32'h0041);
    step();
    check("io_we_end", 32'(io_we), 32'd0);
    read_word("rd0006", 16'h0006, rd);
    check("io_ram_untouched", 32'(rd), 32'h5555);
    io_rdata = 16'h8000;
    set_mdr(16'h0000);
    set_mar(16'hFE04);
    access("io_rd", 1'b0, 1'b1, rd);
    check("io_rd_mdr", 32'(MDROut), 32'h8000);
`else
    // Without MMIO the top addresses alias into RAM and io outputs stay low
    set_mar(16'hFE06);
    set_mdr(16'h0041);
    mem_en = 1'b1; mem_we = 1'b1;
    step();
    mem_en = 1'b0;
    cnt = 0;
    while (!mem_r && cnt < 20) begin
      step();
      cnt++;
    end
    check("noio_lat", 32'(cnt), 32'(WAITC));
    check("noio_we", 32'(io_we), 32'd0);
    check("noio_addr", 32'(io_addr), 32'h0);
    check("noio_wdata", 32'(io_wdata), 32'h0);
    step();
    read_word("rd0006", 16'h0006, rd);
    check("noio_ram", 32'(rd), 32'h0041);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Parametrised successor to the LC-3 MAR/MDR memory block. It holds the MAR and MDR registers and the word-addressed RAM. It adds a handshaked access FSM with configurable wait states, a ready (R) pulse for the control FSM, and captured write data. It sits between the datapath bus and the RAM and replaces the fixed single-cycle memory path.

Parameters:
DATA_W, 16, word width of bus, MDR and RAM
ADDR_W, 16, MAR width
DEPTH_LOG2, 16, RAM depth is 2**DEPTH_LOG2 words; only MAR[DEPTH_LOG2-1:0] indexes RAM
WAIT_CYCLES, 1, cycles from accepted request to R pulse; legal range 1..15
MMIO_BASE, 16'hFE00, first I/O address (used only with MEM_MMIO_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
Bus  in  DATA_W  datapath bus
ldMAR  in  1  load MAR from Bus
ldMARSpcIn  in  1  load MAR from MARSpcIn; has priority over ldMAR
MARSpcIn  in  ADDR_W  special MAR source
ldMDR  in  1  load MDR from the source chosen by selMDR
selMDR  in  2  MDR source: 00 Bus, 01 memory read data, 10 hold, 11 MDRSpcIn
MDRSpcIn  in  DATA_W  special MDR source
mem_en  in  1  access request (MIO.EN)
mem_we  in  1  1 = write, 0 = read; sampled with mem_en
mem_r  out  1  one-cycle ready pulse
busy  out  1  access in flight
mem_rdata  out  DATA_W  read data; valid while mem_r=1
MAROut  out  ADDR_W  MAR contents
MDROut  out  DATA_W  MDR contents
io_we  out  1  MMIO write strobe
io_addr  out  ADDR_W  MMIO address
io_wdata  out  DATA_W  MMIO write data
io_rdata  in  DATA_W  MMIO read data

Behaviour:
- Reset (reset=0, asynchronous): MAROut=0, MDROut=0, state IDLE, mem_r=0, busy=0, io_we=0, wait counter=0. RAM contents are not reset. Reset during an access aborts it; a pending write is never committed.
- MAR load: ldMARSpcIn → MARSpcIn; else ldMAR → Bus; else hold.
- MDR load: only when ldMDR=1. selMDR=01 loads mem_rdata, meaningful only in the mem_r cycle. selMDR=10 holds even if ldMDR=1.
- FSM states:
  - IDLE: mem_en=1 latches MAR into req_addr, latches MDR into req_wdata, latches mem_we, loads counter=WAIT_CYCLES, goes to BUSY.
  - BUSY: busy=1; counter decrements each cycle; at counter==1 goes to DONE.
  - DONE: mem_r=1 for exactly one cycle, busy=0. A write commits req_wdata to RAM[req_addr] at the closing edge. mem_rdata is valid this cycle. mem_en=1 in DONE starts a new access directly (DONE→BUSY), giving back-to-back throughput of one access per WAIT_CYCLES+1 cycles; otherwise the FSM returns to IDLE.
- Latency: mem_en sampled at edge N → mem_r high in cycle N+WAIT_CYCLES.
- mem_en while BUSY is ignored, with no queuing. MAR/MDR loads while BUSY are allowed and do not affect the in-flight access, because address and data are latched.
- mem_rdata outside the mem_r cycle holds its last value.
- Address wrap: MAR bits above DEPTH_LOG2 are ignored for RAM indexing (aliasing).
- Write-then-read to the same address returns the new data.

Optional Feature:
MEM_MMIO_EN.
- Defined: req_addr >= MMIO_BASE bypasses the RAM and completes with the same WAIT_CYCLES latency. A read returns io_rdata, sampled in the mem_r cycle. A write pulses io_we for the mem_r cycle, with io_addr=req_addr and io_wdata=req_wdata. The RAM is untouched.
- Not defined: the whole address space goes to the RAM; io_we=0, io_addr=0, io_wdata=0, and io_rdata is ignored.

Decomposition:
- Package mem_pkg:
  - sel_mdr_e enum: SEL_BUS=2'b00, SEL_MEM=2'b01, SEL_HOLD=2'b10, SEL_SPC=2'b11
  - mem_state_e enum: IDLE, BUSY, DONE
  - default MMIO_BASE constant
- One sub-module, mem_array: single-port synchronous RAM, 2**DEPTH_LOG2 x DATA_W, write on edge when wren, registered 1-cycle read.
- mem_ctrl issues the array read so that q is valid in the DONE cycle.

Test Plan:
- Reset mid-write: MAR=0x3000, MDR=0xBEEF, mem_en=1, mem_we=1, WAIT_CYCLES=3; drop reset in BUSY → no mem_r; later read of 0x3000 does not return 0xBEEF.
- Write then read: write 0x1234 to 0x0040; read 0x0040 with ldMDR=1, selMDR=01 → mem_r exactly WAIT_CYCLES cycles after each request; MDROut=0x1234.
- Back-to-back: mem_en held high for two reads, 0x0010 then 0x0011 → two mem_r pulses spaced WAIT_CYCLES+1 cycles apart; busy low only in the DONE cycles.
- Priority/ignore: ldMAR and ldMARSpcIn together → MAROut=MARSpcIn. mem_en pulsed during BUSY → still exactly one mem_r.
- Aliasing: DEPTH_LOG2=8; write 0xAAAA to 0x0105; read 0x0005 → 0xAAAA.
- MEM_MMIO_EN: write 0x0041 to 0xFE06 → io_we pulse with io_addr=0xFE06, io_wdata=0x0041, RAM unchanged. Read 0xFE04 with io_rdata=0x8000 → MDROut=0x8000.
